// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe board logic.
package tictactoe_pkg;

  localparam int unsigned NUM_CELLS     = 9;
  localparam int unsigned NUM_WIN_LINES = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b10,
    O     = 2'b11
  } cellStateType;

  typedef enum logic [1:0] {
    START   = 2'd0,
    PLAYER1 = 2'd1,
    PLAYER2 = 2'd2,
    END     = 2'd3
  } gameStateType;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FULLCHK,
    ST_DONE
  } scan_state_t;

  typedef logic [3:0] cell_idx_t;

  // Rows, then columns, then main diagonal, then anti-diagonal.
  localparam cell_idx_t WIN_LINES [NUM_WIN_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // True for a value a player may place (X or O).
  function automatic logic is_mark(input logic [1:0] v);
    return (v == X) || (v == O);
  endfunction

endpackage

// File: rtl/win_line_check.sv
// Combinational check of one win line: three equal, non-empty cells.
module win_line_check
  import tictactoe_pkg::*;
#(
  parameter int CELL_W = 2
) (
  input  logic [CELL_W-1:0] cell_a,
  input  logic [CELL_W-1:0] cell_b,
  input  logic [CELL_W-1:0] cell_c,
  output logic              match,
  output logic [CELL_W-1:0] owner
);

  // Match when all three cells hold the same player mark.
  always_comb begin
    match = (cell_a != CELL_W'(EMPTY)) && (cell_a == cell_b) && (cell_b == cell_c);
    owner = match ? cell_a : CELL_W'(EMPTY);
  end

endmodule

// File: rtl/board_state_checker.sv
// Tic-tac-toe board: validates cell writes, then serially scans win lines
// and reports win/draw back to the game controller.
module board_state_checker
  import tictactoe_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int CELL_W    = 2,
  parameter int NUM_LINES = 8
) (
  input  logic                ph1,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [CELL_W-1:0]   cellState,
  input  logic [1:0]          gameState,
  output logic                writeAck,
  output logic                writeErr,
  output logic                busy,
  output logic                gameIsDone,
  output logic [CELL_W-1:0]   winner,
  output logic [9*CELL_W-1:0] board
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(NUM_CELLS - 1);

  scan_state_t                              state_q, state_d;
  logic [NUM_CELLS-1:0][CELL_W-1:0]         board_q, board_d;
  logic [IDX_W-1:0]                         idx_q, idx_d;
  logic                                     ack_q, ack_d;
  logic                                     err_q, err_d;
  logic                                     done_q, done_d;
  logic [CELL_W-1:0]                        winner_q, winner_d;

  logic              write_req;
  logic              write_ok;
  logic              board_full;
  logic [CELL_W-1:0] line_a, line_b, line_c;
  logic              line_match;
  logic [CELL_W-1:0] line_owner;

  // Select the three registered cells of the line currently being scanned.
  always_comb begin
    line_a = board_q[WIN_LINES[idx_q][0]];
    line_b = board_q[WIN_LINES[idx_q][1]];
    line_c = board_q[WIN_LINES[idx_q][2]];
  end

  win_line_check #(
    .CELL_W (CELL_W)
  ) u_line (
    .cell_a (line_a),
    .cell_b (line_b),
    .cell_c (line_c),
    .match  (line_match),
    .owner  (line_owner)
  );

  // Board is full when no registered cell is empty.
  always_comb begin
    board_full = 1'b1;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (board_q[i] == CELL_W'(EMPTY)) board_full = 1'b0;
    end
  end

  // Classify the incoming request and decide whether it is acceptable.
  always_comb begin
    write_req = (cellState != CELL_W'(EMPTY)) && (gameState != START);
    write_ok  = 1'b0;
    if ((state_q == ST_IDLE) && !done_q && (addr <= MAX_ADDR) &&
        is_mark(cellState) && ((gameState == PLAYER1) || (gameState == PLAYER2))) begin
      write_ok = (board_q[addr] == CELL_W'(EMPTY));
    end
  end

  // Next-state: clear has priority; otherwise handle the write and advance the scan.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    idx_d    = idx_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    done_d   = done_q;
    winner_d = winner_q;

    if (gameState == START) begin
      state_d  = ST_IDLE;
      board_d  = '0;
      idx_d    = '0;
      done_d   = 1'b0;
      winner_d = CELL_W'(EMPTY);
    end else begin
      // write_ok implies IDLE, so this never collides with the scan updates below
      if (write_req) begin
        if (write_ok) begin
          board_d[addr] = cellState;
          ack_d         = 1'b1;
          state_d       = ST_SCAN;
          idx_d         = '0;
        end else begin
          err_d = 1'b1;
        end
      end

      case (state_q)
        ST_SCAN: begin
          if (line_match) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            winner_d = line_owner;
            idx_d    = '0;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_FULLCHK;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_FULLCHK: begin
          if (board_full) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            winner_d = CELL_W'(EMPTY);
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      board_q  <= '0;
      idx_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      winner_q <= CELL_W'(EMPTY);
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      idx_q    <= idx_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      done_q   <= done_d;
      winner_q <= winner_d;
    end
  end

  assign writeAck   = ack_q;
  assign writeErr   = err_q;
  assign busy       = (state_q == ST_SCAN) || (state_q == ST_FULLCHK);
  assign gameIsDone = done_q;
  assign winner     = winner_q;
  assign board      = board_q;

endmodule

// File: tb/tb_board_state_checker.sv
// Scoreboard bench for board_state_checker with a game-level reference model.
module tb_board_state_checker;

  localparam logic [1:0] C_E = 2'b00, C_X = 2'b10, C_O = 2'b11, C_BAD = 2'b01;
  localparam logic [1:0] G_START = 2'd0, G_P1 = 2'd1, G_P2 = 2'd2, G_END = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  addr = '0;
  logic [1:0]  cell_st = 2'b00;
  logic [1:0]  game_st = 2'd0;
  logic        ack, err, busy, done;
  logic [1:0]  winner;
  logic [17:0] board;

  board_state_checker #(
    .ADDR_W    (4),
    .CELL_W    (2),
    .NUM_LINES (8)
  ) dut (
    .ph1        (clk),
    .reset_n    (rst_n),
    .addr       (addr),
    .cellState  (cell_st),
    .gameState  (game_st),
    .writeAck   (ack),
    .writeErr   (err),
    .busy       (busy),
    .gameIsDone (done),
    .winner     (winner),
    .board      (board)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ack;
    logic [17:0] brd;
  } resp_t;

  typedef struct {
    int         cycles;
    bit         fin;
    logic [1:0] win;
  } scan_t;

  resp_t rq[$];
  scan_t sq[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [1:0] m_cell [9];
  bit         m_done;
  int         m_end;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cell j (0..2) of win line k: rows, columns, main diagonal, anti-diagonal.
  function automatic int line_cell(input int k, input int j);
    if (k < 3)       return k * 3 + j;
    else if (k < 6)  return (k - 3) + 3 * j;
    else if (k == 6) return 4 * j;
    else             return 2 + 2 * j;
  endfunction

  function automatic int first_line(output logic [1:0] w);
    w = C_E;
    for (int k = 0; k < 8; k++) begin
      if (m_cell[line_cell(k, 0)] != C_E &&
          m_cell[line_cell(k, 0)] == m_cell[line_cell(k, 1)] &&
          m_cell[line_cell(k, 1)] == m_cell[line_cell(k, 2)]) begin
        w = m_cell[line_cell(k, 0)];
        return k;
      end
    end
    return -1;
  endfunction

  function automatic logic [17:0] pack_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = m_cell[i];
    return b;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < 9; i++) if (m_cell[i] == C_E) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_cell[i] = C_E;
    m_done = 1'b0;
    m_end  = 0;
  endtask

  // Drive one cycle of inputs and record the expected responses.
  task automatic issue(input logic [3:0] a, input logic [1:0] v, input logic [1:0] g);
    int         e, k;
    bit         acc;
    logic [1:0] w;
    resp_t      r;
    scan_t      s;
    @(negedge clk);
    addr    = a;
    cell_st = v;
    game_st = g;
    e = cyc + 1;
    if (g == G_START) begin
      model_clear();
    end else if (v != C_E) begin
      acc = (g == G_P1 || g == G_P2) && !m_done && (e > m_end) &&
            (v == C_X || v == C_O) && (a <= 4'd8);
      if (acc) acc = (m_cell[a] == C_E);
      if (acc) begin
        m_cell[a] = v;
        k = first_line(w);
        if (k >= 0) begin
          s.cycles = k + 1; s.fin = 1'b1; s.win = w;
          m_done = 1'b1; m_end = e + 1 + k;
        end else begin
          s.cycles = 9; s.fin = model_full(); s.win = C_E;
          m_done = s.fin; m_end = e + 9;
        end
        sq.push_back(s);
      end
      r.is_ack = acc;
      r.brd    = pack_board();
      rq.push_back(r);
    end
    @(negedge clk);
    cell_st = C_E;
    game_st = G_P1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  // Monitor: pop expectations whenever the DUT pulses a response or ends a scan.
  initial begin
    int    bcnt;
    resp_t r;
    scan_t s;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rq.delete();
        sq.delete();
        bcnt = 0;
      end else begin
        if (ack || err) begin
          if (rq.size() == 0) begin
            check("unexpected_resp", {30'd0, ack, err}, 0);
          end else begin
            r = rq.pop_front();
            check("resp_kind", {30'd0, ack, err}, r.is_ack ? 32'd2 : 32'd1);
            check("board_after_write", board, r.brd);
          end
        end
        if (busy) begin
          bcnt++;
        end else if (bcnt > 0) begin
          if (sq.size() == 0) begin
            check("unexpected_scan", bcnt, 0);
          end else begin
            s = sq.pop_front();
            check("scan_cycles", bcnt, s.cycles);
            check("scan_done", done, s.fin);
            check("scan_winner", winner, s.win);
          end
          bcnt = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int         sel;
    logic [3:0] ra;
    logic [1:0] rv, rg;
    model_clear();

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_board", board, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_winner", winner, 0);
    check("rst_ack_err", {30'd0, ack, err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    game_st = G_P1;

    // 1: reset during a scan
    issue(4'd4, C_X, G_P1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midscan_rst_board", board, 0);
    check("midscan_rst_busy", busy, 0);
    check("midscan_rst_done", done, 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_pulse", {30'd0, ack, err}, 0);
    end

    // 2: row win for X
    issue(4'd0, C_X, G_P1); wait_idle();
    issue(4'd3, C_O, G_P2); wait_idle();
    issue(4'd1, C_X, G_P1); wait_idle();
    issue(4'd4, C_O, G_P2); wait_idle();
    issue(4'd2, C_X, G_P1); wait_idle();
    check("row_win_done", done, 1);
    check("row_win_winner", winner, C_X);
    issue(4'd0, C_E, G_START);

    // 3: illegal writes
    issue(4'd0, C_X, G_P1); wait_idle();
    issue(4'd0, C_O, G_P2);
    issue(4'd9, C_X, G_P1);
    issue(4'd15, C_X, G_P1);
    issue(4'd5, C_BAD, G_P1);
    issue(4'd8, C_X, G_P1);
    issue(4'd5, C_X, G_P2);
    wait_idle();
    issue(4'd0, C_E, G_START);

    // 4: draw
    issue(4'd0, C_X, G_P1); wait_idle();
    issue(4'd1, C_O, G_P2); wait_idle();
    issue(4'd2, C_X, G_P1); wait_idle();
    issue(4'd3, C_X, G_P2); wait_idle();
    issue(4'd4, C_O, G_P1); wait_idle();
    issue(4'd5, C_O, G_P2); wait_idle();
    issue(4'd6, C_O, G_P1); wait_idle();
    issue(4'd7, C_X, G_P2); wait_idle();
    issue(4'd8, C_X, G_P1); wait_idle();
    check("draw_done", done, 1);
    check("draw_winner", winner, C_E);
    issue(4'd4, C_X, G_P1);
    issue(4'd0, C_O, G_END);
    issue(4'd0, C_E, G_START);

    // 5: anti-diagonal win for O, then clear with a coincident write
    issue(4'd0, C_X, G_P1); wait_idle();
    issue(4'd2, C_O, G_P2); wait_idle();
    issue(4'd1, C_X, G_P1); wait_idle();
    issue(4'd4, C_O, G_P2); wait_idle();
    issue(4'd5, C_X, G_P1); wait_idle();
    issue(4'd6, C_O, G_P2); wait_idle();
    check("antidiag_winner", winner, C_O);
    issue(4'd0, C_X, G_START);
    check("clear_board", board, 0);
    check("clear_done", done, 0);
    check("clear_no_ack", {30'd0, ack, err}, 0);

    // Randomized games
    for (int g = 0; g < 20; g++) begin
      wait_idle();
      issue(4'd0, C_E, G_START);
      for (int n = 0; n < 25; n++) begin
        if ($urandom_range(0, 3) != 0) wait_idle();
        ra = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        sel = $urandom_range(0, 9);
        case (sel)
          0:          rv = C_BAD;
          1:          rv = C_E;
          2, 3, 4, 5: rv = C_X;
          default:    rv = C_O;
        endcase
        rg = ($urandom_range(0, 9) == 0) ? G_END : (($urandom_range(0, 1) == 1) ? G_P2 : G_P1);
        issue(ra, rv, rg);
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("resp_queue_drain", rq.size(), 0);
    check("scan_queue_drain", sq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
